// File: rtl/pbs_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package pbs_pkg;

    typedef enum logic [1:0] {
        SM_LOG = 2'b00,
        SM_ASR = 2'b01,
        SM_ROT = 2'b10,
        SM_RSV = 2'b11
    } shift_mode_e;

    // Control part of the stage payload; data, mag, tag and sticky are sized per instance.
    typedef struct packed {
        logic        dir;
        shift_mode_e mode;
    } pbs_ctl_t;

    function automatic int pbs_latency(input int width, input int reg_every);
        return ($clog2(width) + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/pbs_stage.sv
// One pipeline stage: NLVL shift levels starting at FIRST_LVL, then an enable-gated register.
// Sticky tracking is compiled in only when PBS_STICKY_EN is defined.
module pbs_stage
    import pbs_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SHW       = 6,
    parameter int TAG_W     = 4,
    parameter int FIRST_LVL = 0,
    parameter int NLVL      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   mag_i,
    input  pbs_ctl_t         ctl_i,
    input  logic [TAG_W-1:0] tag_i,
`ifdef PBS_STICKY_EN
    input  logic             sticky_i,
    output logic             sticky_o,
`endif
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o,
    output logic [SHW-1:0]   mag_o,
    output pbs_ctl_t         ctl_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int L = $clog2(WIDTH);

    logic [NLVL:0][WIDTH-1:0] d;
    logic [NLVL:0]            s;

    assign d[0] = data_i;
`ifdef PBS_STICKY_EN
    assign s[0] = sticky_i;
`else
    assign s[0] = 1'b0;
`endif

    for (genvar j = 0; j < NLVL; j++) begin : g_lvl
        localparam int LVL = FIRST_LVL + j;
        if (LVL < L) begin : g_mux
            localparam int SH = 1 << LVL;
            logic [WIDTH-1:0] cur, res;
            logic             lost;
            assign cur = d[j];
            always_comb begin
                res  = cur;
                lost = 1'b0;
                if (mag_i[LVL]) begin
                    if (ctl_i.mode == SM_ROT) begin
                        res = ctl_i.dir ? {cur[SH-1:0], cur[WIDTH-1:SH]}
                                        : {cur[WIDTH-SH-1:0], cur[WIDTH-1:WIDTH-SH]};
                    end else if (ctl_i.dir) begin
                        // Right: ASR fills with the sign, everything else (incl. reserved) with 0.
                        res  = {{SH{(ctl_i.mode == SM_ASR) && cur[WIDTH-1]}}, cur[WIDTH-1:SH]};
                        lost = |cur[SH-1:0];
                    end else begin
                        res  = {cur[WIDTH-SH-1:0], {SH{1'b0}}};
                        lost = |cur[WIDTH-1:WIDTH-SH];
                    end
                end
            end
            assign d[j+1] = res;
            assign s[j+1] = s[j] | lost;
        end else begin : g_pass
            assign d[j+1] = d[j];
            assign s[j+1] = s[j];
        end
    end

    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   mag_q;
    pbs_ctl_t         ctl_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            mag_q  <= '0;
            ctl_q  <= '0;
            tag_q  <= '0;
        end else if (en_i) begin
            vld_q  <= vld_i;
            data_q <= d[NLVL];
            mag_q  <= mag_i;
            ctl_q  <= ctl_i;
            tag_q  <= tag_i;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign mag_o  = mag_q;
    assign ctl_o  = ctl_q;
    assign tag_o  = tag_q;

`ifdef PBS_STICKY_EN
    logic sticky_q;
    always_ff @(posedge clk) begin
        if (rst)       sticky_q <= 1'b0;
        else if (en_i) sticky_q <= s[NLVL];
    end
    assign sticky_o = sticky_q;
`else
    logic unused_s;
    assign unused_s = ^s;
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined signed-amount barrel shifter (logical / arithmetic / rotate) with valid/ready.
// Define PBS_STICKY_EN to produce out_sticky (OR of discarded bits); otherwise it is tied 0.
module pipelined_barrel_shifter
    import pbs_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SHW       = $clog2(WIDTH) + 1,
    parameter int REG_EVERY = 1,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sticky
);
    localparam int L   = $clog2(WIDTH);
    localparam int NST = pbs_latency(WIDTH, REG_EVERY);

    logic                       adv;
    logic [NST:0]               vld_pipe;
    logic [NST:0][WIDTH-1:0]    data_p;
    logic [NST:0][SHW-1:0]      mag_p;
    pbs_ctl_t [NST:0]           ctl_p;
    logic [NST:0][TAG_W-1:0]    tag_p;

    logic             in_dir;
    logic [SHW-1:0]   in_mag;
    shift_mode_e      in_mode_e;
    logic [WIDTH-1:0] pre_data;
    logic             pre_sticky;

    // Global stall: every stage moves together whenever the output slot can move.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign in_dir    = in_shamt[SHW-1];
    assign in_mag    = in_dir ? (~in_shamt + 1'b1) : in_shamt;
    assign in_mode_e = shift_mode_e'(in_mode);

    // Only -WIDTH reaches mag bit L; resolve it up front so the levels never see it.
    always_comb begin
        pre_data   = in_data;
        pre_sticky = 1'b0;
        if (in_mag[L]) begin
            case (in_mode_e)
                SM_ROT:  pre_data = in_data;
                SM_ASR:  pre_data = {WIDTH{in_data[WIDTH-1]}};
                default: pre_data = '0;
            endcase
            pre_sticky = (in_mode_e != SM_ROT) && (|in_data);
        end
    end

    assign vld_pipe[0] = in_valid;
    assign data_p[0]   = pre_data;
    assign mag_p[0]    = in_mag;
    assign ctl_p[0]    = '{dir: in_dir, mode: in_mode_e};
    assign tag_p[0]    = in_tag;

`ifdef PBS_STICKY_EN
    logic [NST:0] sticky_p;
    assign sticky_p[0] = pre_sticky;
`endif

    for (genvar i = 0; i < NST; i++) begin : g_stage
        pbs_stage #(
            .WIDTH    (WIDTH),
            .SHW      (SHW),
            .TAG_W    (TAG_W),
            .FIRST_LVL(i * REG_EVERY),
            .NLVL     (REG_EVERY)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (adv),
            .vld_i   (vld_pipe[i]),
            .data_i  (data_p[i]),
            .mag_i   (mag_p[i]),
            .ctl_i   (ctl_p[i]),
            .tag_i   (tag_p[i]),
`ifdef PBS_STICKY_EN
            .sticky_i(sticky_p[i]),
            .sticky_o(sticky_p[i+1]),
`endif
            .vld_o   (vld_pipe[i+1]),
            .data_o  (data_p[i+1]),
            .mag_o   (mag_p[i+1]),
            .ctl_o   (ctl_p[i+1]),
            .tag_o   (tag_p[i+1])
        );
    end

    assign out_valid = vld_pipe[NST];
    assign out_data  = data_p[NST];
    assign out_tag   = tag_p[NST];

`ifdef PBS_STICKY_EN
    assign out_sticky = sticky_p[NST];
`else
    assign out_sticky = 1'b0;
    logic unused_sticky;
    assign unused_sticky = pre_sticky;
`endif

    logic unused_tail;
    assign unused_tail = ^{mag_p[NST], ctl_p[NST]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench: 8-bit/REG_EVERY=1 instance plus a default-parameter instance.
module tb_pipelined_barrel_shifter;

`ifdef PBS_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_sticky;
    logic [7:0] in_data, out_data;
    logic [3:0] in_shamt, in_tag, out_tag;
    logic [1:0] in_mode;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_sticky;
    logic [31:0] w_in_data, w_out_data;
    logic [5:0]  w_in_shamt;
    logic [3:0]  w_in_tag, w_out_tag;
    logic [1:0]  w_in_mode;

    pipelined_barrel_shifter #(.WIDTH(8), .SHW(4), .REG_EVERY(1), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_sticky(out_sticky)
    );

    pipelined_barrel_shifter u_dut32 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .in_shamt(w_in_shamt), .in_mode(w_in_mode), .in_tag(w_in_tag), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_data(w_out_data), .out_tag(w_out_tag),
        .out_sticky(w_out_sticky)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic vec8(input string nm, input logic [7:0] d, input logic [3:0] sh,
                        input logic [1:0] md, input logic [3:0] tg,
                        input logic [7:0] ed, input logic es);
        int n;
        in_valid = 1'b1; in_data = d; in_shamt = sh; in_mode = md; in_tag = tg;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({nm, "_lat"}, 64'(n), 64'd3);
        check_val({nm, "_data"}, 64'(out_data), 64'(ed));
        check_val({nm, "_tag"}, 64'(out_tag), 64'(tg));
        check_val({nm, "_sticky"}, 64'(out_sticky), 64'(es & STK));
        @(posedge clk); #1;
    endtask

    task automatic vec32(input string nm, input logic [31:0] d, input logic [5:0] sh,
                         input logic [1:0] md, input logic [31:0] ed, input logic es);
        int n;
        w_in_valid = 1'b1; w_in_data = d; w_in_shamt = sh; w_in_mode = md; w_in_tag = 4'h9;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        n = 1;
        while (!w_out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({nm, "_lat"}, 64'(n), 64'd5);
        check_val({nm, "_data"}, 64'(w_out_data), 64'(ed));
        check_val({nm, "_sticky"}, 64'(w_out_sticky), 64'(es & STK));
        @(posedge clk); #1;
    endtask

    initial begin
        int   tx, rx, cyc;
        logic held_v, extra;
        logic [7:0] hd;
        logic [3:0] ht;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b1;
        w_in_data = '0; w_in_shamt = '0; w_in_mode = '0; w_in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_data", 64'(out_data), 64'd0);
        check_val("rst_out_tag", 64'(out_tag), 64'd0);
        check_val("rst_out_sticky", 64'(out_sticky), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // shamt encodings (4-bit): -3=D, -8=8, -1=F; modes LOG=0 ASR=1 ROT=2 RSV=3
        vec8("asr_m3",    8'h96, 4'hD, 2'd1, 4'h1, 8'hF2, 1'b1);
        vec8("rot_p3",    8'h96, 4'h3, 2'd2, 4'h2, 8'hB4, 1'b0);
        vec8("rot_m8",    8'h96, 4'h8, 2'd2, 4'h3, 8'h96, 1'b0);
        vec8("log_m8",    8'h96, 4'h8, 2'd0, 4'h4, 8'h00, 1'b1);
        vec8("asr_m8",    8'h96, 4'h8, 2'd1, 4'h5, 8'hFF, 1'b1);
        vec8("lsl_p1",    8'h96, 4'h1, 2'd0, 4'h6, 8'h2C, 1'b1);
        for (int m = 0; m < 4; m++)
            vec8($sformatf("zero_m%0d", m), 8'h96, 4'h0, 2'(m), 4'(m + 7), 8'h96, 1'b0);
        vec8("lsr_m1",    8'h96, 4'hF, 2'd0, 4'hB, 8'h4B, 1'b0);
        vec8("rsv_m3",    8'h96, 4'hD, 2'd3, 4'hC, 8'h12, 1'b1);
        vec8("rot_m3",    8'h96, 4'hD, 2'd2, 4'hD, 8'hD2, 1'b0);
        vec8("asrl_p2",   8'h96, 4'h2, 2'd1, 4'hE, 8'h58, 1'b1);
        vec8("lsl_p7",    8'h01, 4'h7, 2'd0, 4'hF, 8'h80, 1'b0);
        vec8("asr_m8pos", 8'h7F, 4'h8, 2'd1, 4'h0, 8'h00, 1'b1);
        vec8("rsv_m8",    8'h96, 4'h8, 2'd3, 4'h1, 8'h00, 1'b1);

        vec32("w_asr_m1",  32'h8000_0001, 6'h3F, 2'd1, 32'hC000_0000, 1'b1);
        vec32("w_rot_p4",  32'h1234_5678, 6'h04, 2'd2, 32'h2345_6781, 1'b0);
        vec32("w_asr_m32", 32'h8000_0000, 6'h20, 2'd1, 32'hFFFF_FFFF, 1'b1);
        vec32("w_lsl_p31", 32'h0000_FFFF, 6'h1F, 2'd0, 32'h8000_0000, 1'b1);

        // Stream of nibble-swaps with a three-cycle downstream stall.
        tx = 0; rx = 0; cyc = 0; held_v = 1'b0; hd = '0; ht = '0;
        while (rx < 10 && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            if (tx < 10) begin
                in_valid = 1'b1; in_data = {4'(tx), 4'(9 - tx)};
                in_shamt = 4'h4; in_mode = 2'd2; in_tag = 4'(tx);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held_v) begin
                check_val("stall_valid", 64'(out_valid), 64'd1);
                check_val("stall_data", 64'(out_data), 64'(hd));
                check_val("stall_tag", 64'(out_tag), 64'(ht));
            end
            held_v = out_valid && !out_ready;
            hd = out_data; ht = out_tag;
            if (out_valid && out_ready) begin
                check_val($sformatf("stream_data%0d", rx), 64'(out_data), 64'({4'(9 - rx), 4'(rx)}));
                check_val($sformatf("stream_tag%0d", rx), 64'(out_tag), 64'(rx));
                rx++;
            end
            if (in_valid && in_ready) tx++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check_val("stream_count", 64'(rx), 64'd10);
        extra = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            extra |= out_valid;
        end
        check_val("stream_nodup", 64'(extra), 64'd0);

        // Fill the pipe with three items, hold output, then reset.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'h96; in_shamt = 4'h1; in_mode = 2'd0; in_tag = 4'(k + 5);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_val("flight_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check_val("mid_rst_valid", 64'(out_valid), 64'd0);
        check_val("mid_rst_data", 64'(out_data), 64'd0);
        check_val("mid_rst_tag", 64'(out_tag), 64'd0);
        check_val("mid_rst_sticky", 64'(out_sticky), 64'd0);
        check_val("mid_rst_in_ready", 64'(in_ready), 64'd1);
        extra = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            extra |= out_valid;
        end
        check_val("mid_rst_none_emitted", 64'(extra), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
